hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage PA-RISC core (IF, ID, EX, MEM, WB). It shadows the ID/EX, EX/MEM and MEM/WB destination information in its own tag pipeline. From those tags and the decoded control of the instruction in ID, it generates operand-forwarding selects, load-use and PSW-carry stalls, and the wrong-path flush for taken branches with one delay slot. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_unit.sv | 108 ++++++++++
 tb/tb_hazard_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core: shadows destination tags of
// EX/MEM/WB, produces forwarding selects, load-use and carry stalls, and branch flush.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [1:0]       id_sr,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_le,
  input  logic             id_load,
  input  logic             id_psw_le,
  input  logic             id_psw_re,
  input  logic             ex_taken,
  output logic             stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  // Only the fields each stage still needs are kept: WB never stalls, MEM never load-stalls.
  logic       r_ex_v, r_ex_rf_le, r_ex_load, r_ex_psw_le;
  logic [4:0] r_ex_rd;
  logic       r_mem_v, r_mem_rf_le, r_mem_psw_le;
  logic [4:0] r_mem_rd;
  logic       r_wb_v, r_wb_rf_le;
  logic [4:0] r_wb_rd;
  logic [CNT_W-1:0] r_cnt;

  logic       w_lu, w_cs, w_stall;
  logic [4:0] w_rs [2];
  logic [1:0] w_fwd [2];

  assign w_rs[0] = id_rs1;
  assign w_rs[1] = id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_ex_hit, w_mem_hit, w_wb_hit;
      assign w_ex_hit  = r_ex_v  & r_ex_rf_le  & (r_ex_rd  == w_rs[gi]) & (w_rs[gi] != 5'd0);
      assign w_mem_hit = r_mem_v & r_mem_rf_le & (r_mem_rd == w_rs[gi]) & (w_rs[gi] != 5'd0);
      assign w_wb_hit  = r_wb_v  & r_wb_rf_le  & (r_wb_rd  == w_rs[gi]) & (w_rs[gi] != 5'd0);

      always_comb begin
        w_fwd[gi] = 2'b00;
        if (w_ex_hit)       w_fwd[gi] = 2'b01;
        else if (w_mem_hit) w_fwd[gi] = 2'b10;
        else if (w_wb_hit)  w_fwd[gi] = 2'b11;
      end
    end
  endgenerate

  assign w_lu = r_ex_v & r_ex_load & r_ex_rf_le & (r_ex_rd != 5'd0) &
                ((id_sr[0] & (id_rs1 == r_ex_rd)) | (id_sr[1] & (id_rs2 == r_ex_rd)));

  // PSW carry is written at the end of WB, so only EX and MEM producers block a reader.
  assign w_cs = id_valid & id_psw_re &
                ((r_ex_v & r_ex_psw_le) | (r_mem_v & r_mem_psw_le));

  assign w_stall = id_valid & (w_lu | w_cs);

  assign stall       = rst_n & w_stall;
  assign idex_bubble = rst_n & w_stall;
  assign ifid_flush  = rst_n & ex_taken & ~w_stall;
  assign fwd_a       = rst_n ? w_fwd[0] : 2'b00;
  assign fwd_b       = rst_n ? w_fwd[1] : 2'b00;
  assign stall_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v       <= 1'b0;
      r_ex_rf_le   <= 1'b0;
      r_ex_load    <= 1'b0;
      r_ex_psw_le  <= 1'b0;
      r_ex_rd      <= 5'd0;
      r_mem_v      <= 1'b0;
      r_mem_rf_le  <= 1'b0;
      r_mem_psw_le <= 1'b0;
      r_mem_rd     <= 5'd0;
      r_wb_v       <= 1'b0;
      r_wb_rf_le   <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_cnt        <= '0;
    end else begin
      r_wb_v       <= r_mem_v;
      r_wb_rf_le   <= r_mem_rf_le;
      r_wb_rd      <= r_mem_rd;
      r_mem_v      <= r_ex_v;
      r_mem_rf_le  <= r_ex_rf_le;
      r_mem_psw_le <= r_ex_psw_le;
      r_mem_rd     <= r_ex_rd;
      r_ex_v       <= id_valid & ~w_stall;
      r_ex_rf_le   <= id_rf_le;
      r_ex_load    <= id_load;
      r_ex_psw_le  <= id_psw_le;
      r_ex_rd      <= id_rd;
      if (w_stall && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a tag-history model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic [1:0] id_sr = 2'b00;
  logic       id_rf_le = 1'b0, id_load = 1'b0, id_psw_le = 1'b0, id_psw_re = 1'b0;
  logic       ex_taken = 1'b0;

  logic        stall, idex_bubble, ifid_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic        stall4, idex_bubble4, ifid_flush4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  stall_count4;

  int vectors = 0;
  int miscompares = 0;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_sr(id_sr), .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
    .id_psw_le(id_psw_le), .id_psw_re(id_psw_re), .ex_taken(ex_taken),
    .stall(stall), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_sr(id_sr), .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
    .id_psw_le(id_psw_le), .id_psw_re(id_psw_re), .ex_taken(ex_taken),
    .stall(stall4), .idex_bubble(idex_bubble4), .ifid_flush(ifid_flush4),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_count(stall_count4)
  );

  always #5 clk = ~clk;

  // Model: history of what entered EX over the last three edges (index 0 = EX, 1 = MEM, 2 = WB).
  logic       m_v   [3] = '{default: 1'b0};
  logic       m_rf  [3] = '{default: 1'b0};
  logic       m_ld  [3] = '{default: 1'b0};
  logic       m_psw [3] = '{default: 1'b0};
  logic [4:0] m_rd  [3] = '{default: 5'd0};
  int         m_cnt16 = 0;
  int         m_cnt4  = 0;

  function automatic logic raw_stall();
    logic lu, cs;
    lu = m_v[0] && m_ld[0] && m_rf[0] && (m_rd[0] != 5'd0) &&
         ((id_sr[0] && id_rs1 == m_rd[0]) || (id_sr[1] && id_rs2 == m_rd[0]));
    cs = id_valid && id_psw_re && ((m_v[0] && m_psw[0]) || (m_v[1] && m_psw[1]));
    return id_valid && (lu || cs);
  endfunction

  function automatic int exp_fwd(logic [4:0] rs);
    if (!rst_n || rs == 5'd0) return 0;
    for (int i = 0; i < 3; i++)
      if (m_v[i] && m_rf[i] && m_rd[i] == rs) return i + 1;
    return 0;
  endfunction

  function automatic int exp_stall();
    return (rst_n && raw_stall()) ? 1 : 0;
  endfunction

  function automatic int exp_flush();
    return (rst_n && ex_taken && !raw_stall()) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] <= 1'b0; m_rf[i] <= 1'b0; m_ld[i] <= 1'b0; m_psw[i] <= 1'b0; m_rd[i] <= 5'd0;
      end
      m_cnt16 <= 0;
      m_cnt4  <= 0;
    end else begin
      for (int i = 1; i < 3; i++) begin
        m_v[i] <= m_v[i-1]; m_rf[i] <= m_rf[i-1]; m_ld[i] <= m_ld[i-1];
        m_psw[i] <= m_psw[i-1]; m_rd[i] <= m_rd[i-1];
      end
      m_v[0]   <= id_valid && !raw_stall();
      m_rf[0]  <= id_rf_le;
      m_ld[0]  <= id_load;
      m_psw[0] <= id_psw_le;
      m_rd[0]  <= id_rd;
      if (raw_stall()) begin
        m_cnt16 <= (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
        m_cnt4  <= (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      end
    end
  end

  // Literal expectations for directed cycles; -1 means not checked.
  string l_name = "";
  int l_stall = -1, l_bub = -1, l_flush = -1, l_fa = -1, l_fb = -1, l_cnt = -1, l_cnt4 = -1;

  task automatic lit_off();
    l_stall = -1; l_bub = -1; l_flush = -1; l_fa = -1; l_fb = -1; l_cnt = -1; l_cnt4 = -1;
  endtask

  task automatic lit(string name, int s, int b, int f, int fa, int fb, int c, int c4);
    l_name = name; l_stall = s; l_bub = b; l_flush = f; l_fa = fa; l_fb = fb;
    l_cnt = c; l_cnt4 = c4;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_lit(string field, int act, int exp);
    if (exp >= 0) chk({l_name, ".", field}, act, exp);
  endtask

  always @(negedge clk) begin
    chk("stall", int'(stall), exp_stall());
    chk("idex_bubble", int'(idex_bubble), exp_stall());
    chk("ifid_flush", int'(ifid_flush), exp_flush());
    chk("fwd_a", int'(fwd_a), exp_fwd(id_rs1));
    chk("fwd_b", int'(fwd_b), exp_fwd(id_rs2));
    chk("stall_count", int'(stall_count), m_cnt16);
    chk("stall4", int'(stall4), exp_stall());
    chk("idex_bubble4", int'(idex_bubble4), exp_stall());
    chk("ifid_flush4", int'(ifid_flush4), exp_flush());
    chk("fwd_a4", int'(fwd_a4), exp_fwd(id_rs1));
    chk("fwd_b4", int'(fwd_b4), exp_fwd(id_rs2));
    chk("stall_count4", int'(stall_count4), m_cnt4);
    chk_lit("stall", int'(stall), l_stall);
    chk_lit("bubble", int'(idex_bubble), l_bub);
    chk_lit("flush", int'(ifid_flush), l_flush);
    chk_lit("fwd_a", int'(fwd_a), l_fa);
    chk_lit("fwd_b", int'(fwd_b), l_fb);
    chk_lit("count", int'(stall_count), l_cnt);
    chk_lit("count4", int'(stall_count4), l_cnt4);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    lit_off();
  endtask

  task automatic setid(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [1:0] sr,
                       logic [4:0] rd, logic rf, logic ld, logic pl, logic pr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_sr = sr; id_rd = rd;
    id_rf_le = rf; id_load = ld; id_psw_le = pl; id_psw_re = pr;
  endtask

  task automatic nop();
    setid(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0; nop(); ex_taken = 1'b0;
    cyc(); lit("reset", 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    nop();
    do_reset();

    // ALU forwarding from EX, MEM, WB, then none
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0, 0);
    cyc(); setid(1, 5'd3, 5'd3, 2'b11, 5'd0, 0, 0, 0, 0); lit("fwd_ex", 0, 0, 0, 1, 1, -1, -1);
    cyc(); lit("fwd_mem", 0, 0, 0, 2, 2, -1, -1);
    cyc(); lit("fwd_wb", 0, 0, 0, 3, 3, -1, -1);
    cyc(); lit("fwd_none", 0, 0, 0, 0, 0, -1, -1);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 0, 0, 0);
    cyc(); setid(1, 5'd0, 5'd0, 2'b11, 5'd0, 0, 0, 0, 0); lit("fwd_gr0", 0, 0, 0, 0, 0, -1, -1);

    // load-use
    cyc(); setid(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1, 0, 0);
    cyc(); setid(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0); lit("lu_c1", 1, 1, 0, 1, 1, -1, -1);
    cyc(); lit("lu_c2", 0, 0, 0, 2, 2, -1, -1);
    cyc(); nop();
    cyc(); setid(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1, 0, 0);
    cyc(); setid(1, 5'd5, 5'd5, 2'b00, 5'd6, 1, 0, 0, 0); lit("lu_unused", 0, 0, 0, 1, 1, -1, -1);

    // carry stall, back to back and with one instruction between
    do_reset();
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd8, 1, 0, 1, 0);
    cyc(); setid(1, 5'd8, 5'd2, 2'b11, 5'd9, 1, 0, 0, 1); lit("cs_c1", 1, 1, 0, 1, -1, 0, 0);
    cyc(); lit("cs_c2", 1, 1, 0, 2, -1, 1, 1);
    cyc(); lit("cs_c3", 0, 0, 0, 3, -1, 2, 2);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd8, 1, 0, 1, 0);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd10, 1, 0, 0, 0);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 0, 1); lit("cs1_c1", 1, 1, 0, -1, -1, 2, -1);
    cyc(); lit("cs1_c2", 0, 0, 0, -1, -1, 3, -1);

    // taken branch with and without a concurrent stall
    cyc(); nop();
    cyc(); nop();
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd4, 1, 0, 0, 0); ex_taken = 1'b1;
    lit("br_flush", 0, 0, 1, -1, -1, -1, -1);
    cyc(); ex_taken = 1'b0; setid(1, 5'd1, 5'd2, 2'b11, 5'd8, 1, 0, 1, 0);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd10, 1, 0, 0, 0);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 0, 1); ex_taken = 1'b1;
    lit("br_stall", 1, 1, 0, -1, -1, -1, -1);
    cyc(); ex_taken = 1'b0; nop();

    // reset asserted during a carry stall
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd8, 1, 0, 1, 0);
    cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 0, 1);
    #2; rst_n = 1'b0; lit("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    cyc(); nop();
    cyc(); rst_n = 1'b1; lit("rel_1", 0, 0, 0, 0, 0, 0, 0);
    cyc(); lit("rel_2", 0, 0, 0, 0, 0, 0, 0);
    cyc(); lit("rel_3", 0, 0, 0, 0, 0, 0, 0);

    // 24 stall cycles: 4-bit counter saturates
    for (int k = 0; k < 12; k++) begin
      cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd8, 1, 0, 1, 0);
      cyc(); setid(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 0, 1);
      cyc();
      cyc();
    end
    cyc(); nop(); lit("sat", 0, 0, 0, -1, -1, 24, 15);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst_n = ($urandom_range(0, 149) != 0);
      setid($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      ex_taken = ($urandom_range(0, 3) == 0);
    end

    cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
